uart_cmd_handler: RTL
=====================

UART_CMD_HANDLER -- requirements
Module: uart_cmd_handler

Interface
REQ-001 Parameter ACK_BYTE, default 8'h3C: reply byte for an accepted command.
REQ-002 Parameter NACK_BYTE, default 8'hC3: reply byte for a rejected byte (parity, format, unknown code).
REQ-003 Port clk  input  1  system clock (48 MHz HFOSC); single clock domain.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port data_received  input  8  byte from uart_rx, valid when rx_done=1.
REQ-006 Port rx_done  input  1  one-cycle strobe from uart_rx.
REQ-007 Port parity_error  input  1  uart_rx parity flag, qualified by rx_done.
REQ-008 Port tx_busy  input  1  uart_tx busy flag.
REQ-009 Port data_to_tx  output  8  reply byte to uart_tx, held stable from start_tx until tx_busy falls.
REQ-010 Port start_tx  output  1  one-cycle request to uart_tx.
REQ-011 Port pwm_enable  output  1  SPWM enable level.
REQ-012 Port shoot  output  1  one-cycle sync trigger pulse.
REQ-013 Port err_count  output  8  saturating count of rejected and dropped bytes.

Function
REQ-014 The FSM SHALL have states IDLE, DECODE, EXEC, SEND and WAIT_TX.
REQ-015 In IDLE, rx_done=1 SHALL capture data_received and parity_error and move to DECODE.
REQ-016 DECODE SHALL register a 4-bit code and a valid flag, then move to EXEC.
REQ-017 Valid codes SHALL be: 0x6 set pwm_enable=1; 0xD clear pwm_enable; 0x9 invert pwm_enable; 0x3 pulse shoot for one cycle.
REQ-018 In EXEC, a valid code SHALL apply its action and load ACK_BYTE; any other code, or a captured parity_error, SHALL load NACK_BYTE, leave pwm_enable unchanged and increment err_count; EXEC then moves to SEND.
REQ-019 pwm_enable and shoot SHALL change on the 3rd rising edge after the edge that sampled rx_done.
REQ-020 In SEND, start_tx SHALL assert for exactly one cycle, on the first cycle with tx_busy=0, then move to WAIT_TX.
REQ-021 WAIT_TX SHALL last at least 2 cycles and SHALL exit only when tx_busy=0: to DECODE if a byte is pending, otherwise to IDLE.
REQ-022 rx_done outside IDLE SHALL store the byte and its parity flag in a 1-deep pending buffer.
REQ-023 If the pending buffer is already full, the new byte SHALL be dropped and err_count incremented.
REQ-024 rx_done arriving in the same cycle that the pending buffer is consumed SHALL be stored, not dropped.
REQ-025 err_count SHALL saturate at 255; a drop and a rejection in the same cycle SHALL add 2, saturating.
REQ-026 start_tx SHALL never assert while tx_busy=1.

Reset
REQ-027 reset=1 SHALL force state=IDLE, pwm_enable=0, shoot=0, start_tx=0, data_to_tx=8'h00, err_count=0 and an empty pending buffer.
REQ-028 reset asserted mid-transaction SHALL abort it with no start_tx and no pwm_enable change; rx_done during reset SHALL be ignored.

Configuration
REQ-029 With CMD_HAMMING_EN defined, a byte SHALL be {1'b1, cw[6:0]}, where cw[i] is Hamming position i+1.
REQ-030 Under CMD_HAMMING_EN, positions 1, 2 and 4 SHALL be parity bits and positions 3, 5, 6, 7 SHALL be code bits d0..d3.
REQ-031 Under CMD_HAMMING_EN, a non-zero syndrome {s4,s2,s1} SHALL flip that position before extraction; bit7=0 SHALL be a format error.
REQ-032 Without CMD_HAMMING_EN, the code SHALL be data_received[3:0], and data_received[7:4]!=0 SHALL be a format error.

Verification
REQ-033 Hamming on: byte 0xB3, tx_busy=0 -> pwm_enable=1 three edges after rx_done; start_tx one cycle later with data_to_tx=0x3C.
REQ-034 Hamming on: byte 0xB7 (single-bit error in bit2) -> corrected to code 0x6, pwm_enable=1, reply 0x3C, err_count unchanged.
REQ-035 Hamming off: byte 0x0D with parity_error=1 -> pwm_enable unchanged, reply 0xC3, err_count=1.
REQ-036 Hamming off: three bytes 0x06, 0x09, 0x03 two cycles apart with tx_busy held high 200 cycles -> third byte dropped, err_count=1; after tx_busy falls, pwm_enable=0 and two replies of 0x3C; shoot never pulses.
REQ-037 reset asserted in SEND with tx_busy=1 -> no start_tx, all outputs at reset values next cycle; a following 0x06 -> normal ACK.
REQ-038 Hamming off: 260 bytes of 0xFF -> err_count=255, no wrap.

Source files
------------

// File: rtl/uart_cmd_handler.sv
`timescale 1ns/1ps
// uart_cmd_handler: decodes one-byte commands from uart_rx, drives the SPWM enable and shoot pulse, and replies ACK/NACK via uart_tx.
// Define CMD_HAMMING_EN to accept Hamming(7,4)-protected command bytes with single-bit correction.
module uart_cmd_handler #(
    parameter logic [7:0] ACK_BYTE  = 8'h3C,
    parameter logic [7:0] NACK_BYTE = 8'hC3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic [7:0] data_to_tx,
    output logic       start_tx,
    output logic       pwm_enable,
    output logic       shoot,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, SEND, WAIT_TX} state_t;

    state_t     state_q, state_d;
    logic       vld_p0_q;
    logic [7:0] rx_data_p0_q;
    logic       rx_par_p0_q;
    logic [7:0] cap_data_q, cap_data_d;
    logic       cap_par_q, cap_par_d;
    logic [7:0] pend_data_q, pend_data_d;
    logic       pend_par_q, pend_par_d;
    logic       pend_full_q, pend_full_d;
    logic [3:0] code_q, code_d;
    logic       code_ok_q, code_ok_d;
    logic       pwm_q, pwm_d;
    logic       shoot_q, shoot_d;
    logic       start_q, start_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [7:0] err_q, err_d;
    logic       wait_cnt_q, wait_cnt_d;
    logic       consume, rx_to_pend, reject, drop;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Returns {ok, code}; ok only for a clean byte carrying a known command code.
    function automatic logic [4:0] decode_byte(input logic [7:0] b, input logic par);
        logic [3:0] code;
        logic       fmt_err;
        logic       known;
`ifdef CMD_HAMMING_EN
        logic [6:0] cw;
        logic [2:0] syn;
        cw     = b[6:0];
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        if (syn != 3'd0)
            cw[syn - 3'd1] = ~cw[syn - 3'd1];
        code    = {cw[6], cw[5], cw[4], cw[2]};
        fmt_err = ~b[7];
`else
        code    = b[3:0];
        fmt_err = |b[7:4];
`endif
        known = (code == 4'h6) || (code == 4'hD) || (code == 4'h9) || (code == 4'h3);
        return {known & ~fmt_err & ~par, code};
    endfunction

    always_comb begin
        state_d     = state_q;
        cap_data_d  = cap_data_q;
        cap_par_d   = cap_par_q;
        pend_data_d = pend_data_q;
        pend_par_d  = pend_par_q;
        pend_full_d = pend_full_q;
        code_d      = code_q;
        code_ok_d   = code_ok_q;
        pwm_d       = pwm_q;
        shoot_d     = 1'b0;
        start_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        wait_cnt_d  = wait_cnt_q;
        consume     = 1'b0;
        reject      = 1'b0;
        drop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    cap_data_d = pend_data_q;
                    cap_par_d  = pend_par_q;
                    consume    = 1'b1;
                    state_d    = DECODE;
                end else if (vld_p0_q) begin
                    cap_data_d = rx_data_p0_q;
                    cap_par_d  = rx_par_p0_q;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                {code_ok_d, code_d} = decode_byte(cap_data_q, cap_par_q);
                state_d             = EXEC;
            end
            EXEC: begin
                if (code_ok_q) begin
                    case (code_q)
                        4'h6:    pwm_d   = 1'b1;
                        4'hD:    pwm_d   = 1'b0;
                        4'h9:    pwm_d   = ~pwm_q;
                        4'h3:    shoot_d = 1'b1;
                        default: pwm_d   = pwm_q;
                    endcase
                    tx_byte_d = ACK_BYTE;
                end else begin
                    tx_byte_d = NACK_BYTE;
                    reject    = 1'b1;
                end
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    start_d    = 1'b1;
                    wait_cnt_d = 1'b0;
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // First cycle is unconditional so uart_tx has time to raise tx_busy.
                if (!wait_cnt_q) begin
                    wait_cnt_d = 1'b1;
                end else if (!tx_busy) begin
                    if (pend_full_q) begin
                        cap_data_d = pend_data_q;
                        cap_par_d  = pend_par_q;
                        consume    = 1'b1;
                        state_d    = DECODE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte goes to the pending slot unless IDLE can take it straight away.
        rx_to_pend = vld_p0_q && !(state_q == IDLE && !pend_full_q);
        if (consume)
            pend_full_d = 1'b0;
        if (rx_to_pend) begin
            if (!pend_full_q || consume) begin
                pend_data_d = rx_data_p0_q;
                pend_par_d  = rx_par_p0_q;
                pend_full_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        err_d = sat_add(err_q, {1'b0, reject} + {1'b0, drop});
    end

    always_ff @(posedge clk) begin
        rx_data_p0_q <= data_received;
        rx_par_p0_q  <= parity_error;
        cap_data_q   <= cap_data_d;
        cap_par_q    <= cap_par_d;
        pend_data_q  <= pend_data_d;
        pend_par_q   <= pend_par_d;
        code_q       <= code_d;
        if (reset) begin
            state_q     <= IDLE;
            vld_p0_q    <= 1'b0;
            pend_full_q <= 1'b0;
            code_ok_q   <= 1'b0;
            pwm_q       <= 1'b0;
            shoot_q     <= 1'b0;
            start_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            err_q       <= 8'h00;
            wait_cnt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_p0_q    <= rx_done;
            pend_full_q <= pend_full_d;
            code_ok_q   <= code_ok_d;
            pwm_q       <= pwm_d;
            shoot_q     <= shoot_d;
            start_q     <= start_d;
            tx_byte_q   <= tx_byte_d;
            err_q       <= err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign data_to_tx = tx_byte_q;
    assign start_tx   = start_q;
    assign pwm_enable = pwm_q;
    assign shoot      = shoot_q;
    assign err_count  = err_q;

endmodule
